// File: rtl/plru_pkg.sv
// Shared definitions for the set-associative tree-PLRU block:
// flush FSM state type, default geometry and tree node-index helpers.
// Optional feature macro used by the block: PLRU_LOCK_EN.
package plru_pkg;

    localparam int unsigned PLRU_DEF_SETS = 16;
    localparam int unsigned PLRU_DEF_WAYS = 8;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } plru_state_e;

    // First node index of a tree level (level 0 is the root).
    function automatic int unsigned lvl_base(input int unsigned lvl);
        return (32'd1 << lvl) - 32'd1;
    endfunction

    // Node at a given level reached by a way-index prefix of lvl bits.
    function automatic int unsigned node_idx(input int unsigned lvl, input int unsigned prefix);
        return lvl_base(lvl) + prefix;
    endfunction

endpackage

// File: rtl/plru_victim_sel.sv
// Combinational victim selection for one PLRU set: lowest usable invalid
// way first, otherwise a tree walk that steers around fully locked subtrees.
// Lock inputs exist only when PLRU_LOCK_EN is defined.
module plru_victim_sel
    import plru_pkg::*;
#(
    parameter int unsigned WAYS = PLRU_DEF_WAYS
) (
    input  logic [WAYS-2:0]         tree_i,
    input  logic [WAYS-1:0]         valid_i,
`ifdef PLRU_LOCK_EN
    input  logic [WAYS-1:0]         lock_i,
    output logic                    fail_o,
`endif
    output logic [$clog2(WAYS)-1:0] way_o
);

    localparam int unsigned WAY_W = $clog2(WAYS);

    logic [WAYS-1:0] lock_w;

`ifdef PLRU_LOCK_EN
    assign lock_w = lock_i;
    assign fail_o = &lock_i;
`else
    assign lock_w = '0;
`endif

    function automatic logic way_bit(input logic [WAYS-1:0] v, input int unsigned i);
        logic [WAYS-1:0] s;
        s = v >> i;
        return s[0];
    endfunction

    function automatic logic node_bit(input logic [WAYS-2:0] t, input int unsigned n);
        logic [WAYS-2:0] s;
        s = t >> n;
        return s[0];
    endfunction

    // Invalid-way priority search, then lock-aware walk from the root.
    always_comb begin
        logic              inv_found;
        logic [WAY_W-1:0]  inv_way;
        logic [WAY_W-1:0]  prefix;
        logic              dir;
        logic              left_free;
        logic              right_free;
        int unsigned       shift;

        inv_found = 1'b0;
        inv_way   = '0;
        prefix    = '0;
        dir       = 1'b0;

        for (int unsigned i = 0; i < WAYS; i++) begin
            if (!inv_found && !way_bit(valid_i, i) && !way_bit(lock_w, i)) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(i);
            end
        end

        for (int unsigned lvl = 0; lvl < WAY_W; lvl++) begin
            // ways whose top (lvl+1) bits equal a child prefix lie in that child
            shift      = WAY_W - lvl - 1;
            left_free  = 1'b0;
            right_free = 1'b0;
            for (int unsigned w = 0; w < WAYS; w++) begin
                if (!way_bit(lock_w, w)) begin
                    if ((w >> shift) == (32'(prefix) << 1))
                        left_free = 1'b1;
                    if ((w >> shift) == ((32'(prefix) << 1) | 32'd1))
                        right_free = 1'b1;
                end
            end
            dir = node_bit(tree_i, node_idx(lvl, 32'(prefix)));
            if (dir && !right_free)
                dir = 1'b0;
            else if (!dir && !left_free)
                dir = 1'b1;
            prefix = (prefix << 1) | WAY_W'(dir);
        end

        if (&lock_w)
            way_o = '0;
        else if (inv_found)
            way_o = inv_way;
        else
            way_o = prefix;
    end

endmodule

// File: rtl/plru_set_assoc.sv
// Tree pseudo-LRU state for SETS independent sets of WAYS ways, with hit
// updates, registered victim responses and a one-set-per-cycle flush.
// Optional lock support (lock_i / repl_fail_o) enabled by PLRU_LOCK_EN.
module plru_set_assoc
    import plru_pkg::*;
#(
    parameter int unsigned SETS = PLRU_DEF_SETS,
    parameter int unsigned WAYS = PLRU_DEF_WAYS
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    access_hit_i,
    input  logic [$clog2(SETS)-1:0] access_set_i,
    input  logic [$clog2(WAYS)-1:0] access_way_i,
    input  logic                    repl_req_i,
    input  logic [$clog2(SETS)-1:0] repl_set_i,
    input  logic [WAYS-1:0]         repl_valid_i,
    output logic                    repl_ready_o,
    output logic                    repl_ack_o,
    output logic [$clog2(WAYS)-1:0] repl_way_o,
    input  logic                    flush_i,
`ifdef PLRU_LOCK_EN
    input  logic [WAYS-1:0]         lock_i,
    output logic                    repl_fail_o,
`endif
    output logic                    busy_o
);

    localparam int unsigned SET_W = $clog2(SETS);
    localparam int unsigned WAY_W = $clog2(WAYS);
    localparam logic [WAYS-2:0] NODE_ONE = (WAYS-1)'(1);

    plru_state_e                 state_q, state_d;
    logic [SET_W-1:0]            cnt_q, cnt_d;
    logic [SETS-1:0][WAYS-2:0]   tree_q, tree_d;
    logic                        ack_q, ack_d;
    logic [WAY_W-1:0]            way_q, way_d;
    logic [WAY_W-1:0]            sel_way;
    logic                        sel_fail;

`ifdef PLRU_LOCK_EN
    logic                        fail_q, fail_d;
`endif

    plru_victim_sel #(
        .WAYS (WAYS)
    ) u_victim_sel (
        .tree_i  (tree_q[repl_set_i]),
        .valid_i (repl_valid_i),
`ifdef PLRU_LOCK_EN
        .lock_i  (lock_i),
        .fail_o  (sel_fail),
`endif
        .way_o   (sel_way)
    );

`ifndef PLRU_LOCK_EN
    assign sel_fail = 1'b0;
`endif

    // Point every node on way w's path away from it (way becomes MRU).
    function automatic logic [WAYS-2:0] mark_mru(input logic [WAYS-2:0] t,
                                                 input logic [WAY_W-1:0] w);
        logic [WAYS-2:0]  r;
        logic [WAYS-2:0]  mask;
        logic [WAY_W-1:0] sh;
        r = t;
        for (int unsigned lvl = 0; lvl < WAY_W; lvl++) begin
            sh   = w >> (WAY_W - 1 - lvl);
            mask = NODE_ONE << node_idx(lvl, 32'(w) >> (WAY_W - lvl));
            if (sh[0])
                r = r & ~mask;
            else
                r = r | mask;
        end
        return r;
    endfunction

    // Next-state: hit then fill updates in IDLE (fill wins on shared nodes), set clearing in FLUSH.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tree_d  = tree_q;
        ack_d   = 1'b0;
        way_d   = way_q;
`ifdef PLRU_LOCK_EN
        fail_d  = fail_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (access_hit_i)
                    tree_d[access_set_i] = mark_mru(tree_d[access_set_i], access_way_i);
                if (repl_req_i) begin
                    ack_d = 1'b1;
                    way_d = sel_way;
`ifdef PLRU_LOCK_EN
                    fail_d = sel_fail;
`endif
                    if (!sel_fail)
                        tree_d[repl_set_i] = mark_mru(tree_d[repl_set_i], sel_way);
                end
                if (flush_i) begin
                    state_d = ST_FLUSH;
                    cnt_d   = '0;
                end
            end
            ST_FLUSH: begin
                tree_d[cnt_q] = '0;
                cnt_d         = cnt_q + 1'b1;
                if (cnt_q == '1)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            tree_q  <= '0;
            ack_q   <= 1'b0;
            way_q   <= '0;
`ifdef PLRU_LOCK_EN
            fail_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tree_q  <= tree_d;
            ack_q   <= ack_d;
            way_q   <= way_d;
`ifdef PLRU_LOCK_EN
            fail_q  <= fail_d;
`endif
        end
    end

    assign repl_ready_o = (state_q == ST_IDLE);
    assign busy_o       = (state_q == ST_FLUSH);
    assign repl_ack_o   = ack_q;
    assign repl_way_o   = way_q;
`ifdef PLRU_LOCK_EN
    assign repl_fail_o  = fail_q;
`endif

endmodule

// File: tb/tb_plru_set_assoc.sv
// Self-checking bench for plru_set_assoc (SETS=16, WAYS=8) against a
// heap-indexed tree model. Lock scenarios compile in with PLRU_LOCK_EN.
module tb_plru_set_assoc;

    localparam int SETS = 16;
    localparam int WAYS = 8;

    logic       clk = 1'b0;
    logic       rstn, hit, req, flush;
    logic [3:0] hset, rset;
    logic [2:0] hway;
    logic [7:0] rvalid;
    logic       ready, ack, busy;
    logic [2:0] way;
`ifdef PLRU_LOCK_EN
    logic [7:0] lock;
    logic       fail;
`endif

    int total = 0;
    int bad   = 0;

    // reference model state
    bit         mtree [SETS][WAYS-1];
    bit         m_busy;
    int         m_cnt;
    logic       m_ack;
    logic [2:0] m_way;
    logic       m_fail;

    always #5 clk = ~clk;

    plru_set_assoc #(
        .SETS (SETS),
        .WAYS (WAYS)
    ) dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .access_hit_i (hit),
        .access_set_i (hset),
        .access_way_i (hway),
        .repl_req_i   (req),
        .repl_set_i   (rset),
        .repl_valid_i (rvalid),
        .repl_ready_o (ready),
        .repl_ack_o   (ack),
        .repl_way_o   (way),
        .flush_i      (flush),
`ifdef PLRU_LOCK_EN
        .lock_i       (lock),
        .repl_fail_o  (fail),
`endif
        .busy_o       (busy)
    );

    function automatic logic [7:0] cur_lock();
`ifdef PLRU_LOCK_EN
        return lock;
`else
        return 8'h00;
`endif
    endfunction

    // Victim by the rules: usable invalid way first, else walk; -1 when all locked.
    function automatic int pick(int s, logic [7:0] v, logic [7:0] lk);
        int node, lo, size, half;
        bit dir, lf, rf;
        if (lk == 8'hFF) return -1;
        for (int w = 0; w < 8; w++)
            if (!v[w] && !lk[w]) return w;
        node = 0; lo = 0; size = 8;
        while (size > 1) begin
            half = size / 2;
            lf = 0; rf = 0;
            for (int w = lo; w < lo + half; w++) if (!lk[w]) lf = 1;
            for (int w = lo + half; w < lo + size; w++) if (!lk[w]) rf = 1;
            dir = mtree[s][node];
            if (dir && !rf) dir = 0;
            else if (!dir && !lf) dir = 1;
            if (dir) lo += half;
            node = 2 * node + 1 + int'(dir);
            size = half;
        end
        return lo;
    endfunction

    task automatic mark(int s, int w);
        int node, lo, size, half;
        bit r;
        node = 0; lo = 0; size = 8;
        while (size > 1) begin
            half = size / 2;
            r = (w >= lo + half);
            mtree[s][node] = ~r;
            if (r) lo += half;
            node = 2 * node + 1 + int'(r);
            size = half;
        end
    endtask

    // Advance model and DUT by one clock; outputs are settled on return.
    task automatic tick();
        int v;
        if (!rstn) begin
            foreach (mtree[s, n]) mtree[s][n] = 0;
            m_busy = 0; m_cnt = 0; m_ack = 0; m_way = 0; m_fail = 0;
        end else if (m_busy) begin
            for (int n = 0; n < WAYS - 1; n++) mtree[m_cnt][n] = 0;
            m_cnt++;
            if (m_cnt == SETS) begin m_busy = 0; m_cnt = 0; end
            m_ack = 0;
        end else begin
            v = req ? pick(int'(rset), rvalid, cur_lock()) : 0;
            if (hit) mark(int'(hset), int'(hway));
            m_ack = req;
            if (req) begin
                if (v < 0) begin
                    m_fail = 1; m_way = 3'd0;
                end else begin
                    m_fail = 0; m_way = 3'(v);
                    mark(int'(rset), v);
                end
            end
            if (flush) begin m_busy = 1; m_cnt = 0; end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        rstn = 1'b1; hit = 1'b0; req = 1'b0; flush = 1'b0;
        hset = '0; rset = '0; hway = '0; rvalid = 8'hFF;
`ifdef PLRU_LOCK_EN
        lock = 8'h00;
`endif
    endtask

    task automatic do_reset();
        quiet();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        quiet();
        rstn = 1'b0; hit = 1'b1; req = 1'b1; flush = 1'b1;
        tick();
        tick();
        total++;
        if (ack !== 1'b0 || way !== 3'd0 || busy !== 1'b0 || ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_state: got ack=%b way=%0d busy=%b ready=%b, expected ack=0 way=0 busy=0 ready=1",
                     ack, way, busy, ready);
        end
        quiet();
        tick();
        total++;
        if (ack !== 1'b0 || ready !== 1'b1) begin
            bad++;
            $display("FAIL after_reset: got ack=%b ready=%b, expected ack=0 ready=1", ack, ready);
        end
    endtask

    task automatic test_directed();
        int exp5 [2] = '{0, 4};
        // first request after reset
        do_reset();
        req = 1'b1; rset = 4'd3; rvalid = 8'hFF;
        tick();
        total++;
        if (ack !== 1'b1 || way !== 3'd0) begin
            bad++;
            $display("FAIL first_req: got ack=%b way=%0d, expected ack=1 way=0", ack, way);
        end
        req = 1'b0;
        tick();
        total++;
        if (ack !== 1'b0 || way !== 3'd0) begin
            bad++;
            $display("FAIL ack_pulse_hold: got ack=%b way=%0d, expected ack=0 way=0", ack, way);
        end
        // hit steers the walk; other sets untouched
        do_reset();
        hit = 1'b1; hset = 4'd2; hway = 3'd0;
        tick();
        hit = 1'b0; req = 1'b1; rset = 4'd2;
        tick();
        total++;
        if (ack !== 1'b1 || way !== 3'd4) begin
            bad++;
            $display("FAIL hit_steer: got ack=%b way=%0d, expected ack=1 way=4", ack, way);
        end
        rset = 4'd3;
        tick();
        total++;
        if (way !== 3'd0) begin
            bad++;
            $display("FAIL set_isolation: got way=%0d, expected way=0", way);
        end
        // hits to all ways in order, then two back-to-back requests
        do_reset();
        hit = 1'b1; hset = 4'd5;
        for (int w = 0; w < 8; w++) begin
            hway = 3'(w);
            tick();
        end
        hit = 1'b0; req = 1'b1; rset = 4'd5;
        for (int k = 0; k < 2; k++) begin
            tick();
            total++;
            if (ack !== 1'b1 || way !== 3'(exp5[k])) begin
                bad++;
                $display("FAIL back_to_back[%0d]: got ack=%b way=%0d, expected ack=1 way=%0d", k, ack, way, exp5[k]);
            end
        end
        // invalid way wins, then becomes MRU
        do_reset();
        req = 1'b1; rset = 4'd1; rvalid = 8'hDF;
        tick();
        total++;
        if (way !== 3'd5) begin
            bad++;
            $display("FAIL invalid_pick: got way=%0d, expected way=5", way);
        end
        rvalid = 8'hFF;
        tick();
        total++;
        if (way !== 3'd0) begin
            bad++;
            $display("FAIL invalid_mru: got way=%0d, expected way=0", way);
        end
        // same-set hit and fill: victim from old state, fill applied last
        do_reset();
        hit = 1'b1; hset = 4'd0; hway = 3'd4;
        req = 1'b1; rset = 4'd0;
        tick();
        total++;
        if (way !== 3'd0) begin
            bad++;
            $display("FAIL same_set_victim: got way=%0d, expected way=0", way);
        end
        hit = 1'b0;
        tick();
        total++;
        if (way !== 3'd6) begin
            bad++;
            $display("FAIL same_set_order: got way=%0d, expected way=6", way);
        end
        quiet();
    endtask

    task automatic test_flush();
        do_reset();
        for (int s = 0; s < SETS; s++) begin
            hit = 1'b1; hset = 4'(s); hway = 3'($urandom_range(0, 7));
            tick();
        end
        // request accepted in the flush cycle still gets its response
        hit = 1'b0; flush = 1'b1; req = 1'b1; rset = 4'd6;
        tick();
        total++;
        if (ack !== 1'b1 || busy !== 1'b1 || ready !== 1'b0) begin
            bad++;
            $display("FAIL flush_start: got ack=%b busy=%b ready=%b, expected ack=1 busy=1 ready=0", ack, busy, ready);
        end
        flush = 1'b1; hit = 1'b1;
        for (int c = 1; c < SETS; c++) begin
            rset = 4'($urandom_range(0, 15));
            hset = rset;
            tick();
            total++;
            if (ack !== 1'b0 || busy !== 1'b1 || ready !== 1'b0) begin
                bad++;
                $display("FAIL flush_busy[%0d]: got ack=%b busy=%b ready=%b, expected ack=0 busy=1 ready=0", c, ack, busy, ready);
            end
        end
        flush = 1'b0; hit = 1'b0; req = 1'b0;
        tick();
        total++;
        if (busy !== 1'b0 || ready !== 1'b1 || ack !== 1'b0) begin
            bad++;
            $display("FAIL flush_end: got busy=%b ready=%b ack=%b, expected busy=0 ready=1 ack=0", busy, ready, ack);
        end
        req = 1'b1;
        for (int s = 0; s < SETS; s++) begin
            rset = 4'(s);
            tick();
            total++;
            if (ack !== 1'b1 || way !== 3'd0) begin
                bad++;
                $display("FAIL flush_cleared[%0d]: got ack=%b way=%0d, expected ack=1 way=0", s, ack, way);
            end
        end
        quiet();
        // reset in the middle of a flush
        hit = 1'b1; hset = 4'd9; hway = 3'd0;
        tick();
        hit = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int c = 0; c < 7; c++) tick();
        rstn = 1'b0; req = 1'b1;
        tick();
        total++;
        if (busy !== 1'b0 || ready !== 1'b1 || ack !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_flush: got busy=%b ready=%b ack=%b, expected busy=0 ready=1 ack=0", busy, ready, ack);
        end
        rstn = 1'b1; rset = 4'd9;
        tick();
        total++;
        if (ack !== 1'b1 || way !== 3'd0) begin
            bad++;
            $display("FAIL after_abort: got ack=%b way=%0d, expected ack=1 way=0", ack, way);
        end
        // response owed at a reset edge is dropped
        flush = 1'b1;
        tick();
        flush = 1'b0; req = 1'b0; rstn = 1'b0;
        tick();
        total++;
        if (ack !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_drops_ack: got ack=%b busy=%b, expected ack=0 busy=0", ack, busy);
        end
        quiet();
    endtask

`ifdef PLRU_LOCK_EN
    task automatic test_lock();
        do_reset();
        req = 1'b1; rset = 4'd0; lock = 8'h0F;
        tick();
        total++;
        if (ack !== 1'b1 || way !== 3'd4 || fail !== 1'b0) begin
            bad++;
            $display("FAIL lock_half: got ack=%b way=%0d fail=%b, expected ack=1 way=4 fail=0", ack, way, fail);
        end
        lock = 8'hFF;
        tick();
        total++;
        if (ack !== 1'b1 || way !== 3'd0 || fail !== 1'b1) begin
            bad++;
            $display("FAIL lock_all: got ack=%b way=%0d fail=%b, expected ack=1 way=0 fail=1", ack, way, fail);
        end
        lock = 8'h00;
        tick();
        total++;
        if (way !== 3'd0 || fail !== 1'b0) begin
            bad++;
            $display("FAIL lock_tree_kept: got way=%0d fail=%b, expected way=0 fail=0", way, fail);
        end
        quiet();
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            rstn   = ($urandom_range(0, 299) != 0);
            hit    = 1'($urandom_range(0, 1));
            hset   = 4'($urandom_range(0, 3));
            hway   = 3'($urandom_range(0, 7));
            req    = 1'($urandom_range(0, 1));
            rset   = 4'($urandom_range(0, 3));
            rvalid = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
            flush  = ($urandom_range(0, 99) == 0);
`ifdef PLRU_LOCK_EN
            lock   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
`endif
            tick();
            total++;
            if (ack !== m_ack || way !== m_way || busy !== m_busy || ready !== !m_busy) begin
                bad++;
                $display("FAIL random[%0d]: got ack=%b way=%0d busy=%b ready=%b, expected ack=%b way=%0d busy=%b ready=%b",
                         c, ack, way, busy, ready, m_ack, m_way, m_busy, !m_busy);
            end
`ifdef PLRU_LOCK_EN
            total++;
            if (fail !== m_fail) begin
                bad++;
                $display("FAIL random_fail[%0d]: got fail=%b, expected fail=%b", c, fail, m_fail);
            end
`endif
        end
        quiet();
    endtask

    initial begin
        quiet();
        test_reset();
        test_directed();
        test_flush();
`ifdef PLRU_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
